pit_axi_lite_slave: RTL
=======================

// Module: pit_axi_lite_slave
// PURPOSE
//  AXI4-Lite responder and programmable interval timer core. It answers the write/read bursts
//  the PS (or the AXI VIP master in simulation) issues. It holds the control, period and
//  live-count registers, and raises irq once per elapsed period when enabled.
//  It sits behind the interconnect in the block design; irq goes to the interrupt controller.
// PARAMETERS
//  DATA_W     32  AXI data width and register width (fixed 32; other values are unsupported)
//  ADDR_W      4  AXI address width; only bits [3:2] are decoded (word-aligned)
// PORTS
//  aclk          in   1        single clock, all logic rising-edge
//  aresetn       in   1        asynchronous active-low reset
//  s_axi_awaddr  in   ADDR_W   write address
//  s_axi_awprot  in   3        ignored
//  s_axi_awvalid in   1        / s_axi_awready out 1
//  s_axi_wdata   in   DATA_W   write data
//  s_axi_wstrb   in   4        byte enables
//  s_axi_wvalid  in   1        / s_axi_wready out 1
//  s_axi_bresp   out  2        write response
//  s_axi_bvalid  out  1        / s_axi_bready in 1
//  s_axi_araddr  in   ADDR_W   read address
//  s_axi_arprot  in   3        ignored
//  s_axi_arvalid in   1        / s_axi_arready out 1
//  s_axi_rdata   out  DATA_W   read data
//  s_axi_rresp   out  2        read response
//  s_axi_rvalid  out  1        / s_axi_rready in 1
//  irq           out  1        one-cycle interrupt pulse
// BEHAVIOUR
//  Register map:
//   - 0x0 CTRL (RW): bit0 = CNT_EN, bit1 = IRQ_EN; other bits read 0.
//   - 0x4 PERIOD (RW, 32b).
//   - 0x8 COUNT (RO).
//   - 0xC unmapped.
//  Reset: all registers 0, irq 0, every ready/valid 0, bresp/rresp 0, rdata 0.
//  Write FSM W_IDLE -> W_RESP:
//   - W_IDLE: accept only when awvalid && wvalid together. Pulse awready = wready = 1 for
//     one cycle and apply wstrb-masked data in that same cycle.
//   - Enter W_RESP with bvalid = 1 on the next cycle. Hold bvalid until bready, then
//     return to W_IDLE. No new write is accepted while bvalid = 1.
//  Read FSM R_IDLE -> R_DATA:
//   - R_IDLE: on arvalid, pulse arready one cycle and capture rdata that cycle.
//   - rvalid = 1 the next cycle; hold rdata/rvalid stable until rready.
//   - Latency: arvalid to rvalid is 1 cycle.
//  Responses:
//   - 0x0/0x4/0x8 -> OKAY (2'b00); 0xC -> SLVERR (2'b10).
//   - Write to 0x8 or 0xC: no register change, response still issued.
//   - Read of 0xC returns 0.
//  Read and write channels are independent; both may complete in the same cycle.
//  Counter:
//   - CNT_EN = 1: each cycle, if COUNT >= PERIOD-1 then COUNT <= 0 and tick = 1,
//     else COUNT <= COUNT + 1.
//   - CNT_EN = 0: COUNT holds its value. It is not cleared, so counting resumes where it stopped.
//   - PERIOD = 0: COUNT held at 0, no ticks.
//   - A PERIOD write does not clear COUNT. If COUNT >= new PERIOD-1, the next enabled cycle
//     wraps and ticks.
//  irq <= tick && IRQ_EN, registered. It is a 1-cycle pulse, one cycle after the wrap.
//  Simultaneous events: a CTRL write takes effect on the cycle after the handshake. The
//   counter uses the pre-write CTRL in the handshake cycle.
//  aresetn low mid-transaction: FSMs go to IDLE immediately and every valid/ready drops
//   asynchronously. The pending transaction is abandoned.
// STRUCTURE
//  pit_pkg:
//   - localparams ADDR_CTRL = 2'd0, ADDR_PERIOD = 2'd1, ADDR_COUNT = 2'd2.
//   - CTRL bit indices CNT_EN_BIT = 0, IRQ_EN_BIT = 1.
//   - RESP_OKAY, RESP_SLVERR.
//   - typedef enums wr_state_t {W_IDLE, W_RESP} and rd_state_t {R_IDLE, R_DATA}.
//  Sub-module pit_counter (inputs cnt_en, irq_en, period; outputs count, irq) holds the
//   timer datapath. The AXI FSMs and register file stay in the top.
// TESTING
//  1. After reset, read 0x0, 0x4, 0x8 -> all 0x0000_0000, resp OKAY; irq never high.
//  2. Write 0x4 = 4, then 0x0 = 3; read back -> 0x3 and 0x4. irq pulses 1 cycle every 4
//     clocks (40 ns at 10 ns clock).
//  3. Write CTRL = 1 -> counting continues, irq stays 0. Write CTRL = 0 -> reads of 0x8 are
//     constant. Write CTRL = 3 -> COUNT resumes from the held value, next irq after the
//     remaining cycles.
//  4. Hold bready = 0 for 5 cycles after a write -> bvalid stays 1. A second awvalid/wvalid is
//     not accepted until bready. Same for rvalid/rready on reads.
//  5. Write 0x0 with wstrb = 4'b0000 -> CTRL unchanged. Write 0xC -> SLVERR; read 0xC ->
//     SLVERR, rdata 0.
//  6. Assert aresetn = 0 while bvalid = 1 -> bvalid, irq, CTRL, PERIOD, COUNT all 0 immediately.

Source files
------------

// File: rtl/pit_pkg.sv
// Shared definitions for the PIT AXI4-Lite slave: register word addresses,
// CTRL bit positions, AXI response codes, FSM state types and a byte-strobe
// merge helper. No ports; imported by the top module.
package pit_pkg;

  // Word index decoded from addr[3:2]; index 3 (0xC) is unmapped.
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CNT_EN_BIT = 0;
  localparam int IRQ_EN_BIT = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Replace only the bytes whose strobe bit is set.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pit_axi_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the PIT (slave).
// Ports: none; parameters ADDR_W (address width) and DATA_W (data width).
// Signals follow AXI4-Lite channel naming without the s_axi_ prefix;
// the prefix comes from the instance name on the slave port (s_axi.awaddr).
interface pit_axi_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/pit_counter.sv
// Programmable interval timer datapath.
// Ports:
//   aclk, aresetn   clock, asynchronous active-low reset
//   cnt_en          count enable (CTRL bit 0)
//   irq_en          interrupt enable (CTRL bit 1)
//   period          wrap period in cycles; 0 parks the counter at 0
//   count           live count value
//   irq             registered one-cycle pulse, one cycle after a wrap
module pit_counter #(
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cnt_en,
  input  logic              irq_en,
  input  logic [DATA_W-1:0] period,
  output logic [DATA_W-1:0] count,
  output logic              irq
);
  logic [DATA_W-1:0] last_val;
  logic              tick;

  assign last_val = period - DATA_W'(1);
  // ">=" rather than "==" so a PERIOD shrunk below the live count wraps on
  // the next enabled cycle instead of running all the way round.
  assign tick = cnt_en && (period != '0) && (count >= last_val);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
      irq   <= 1'b0;
    end else begin
      irq <= tick && irq_en;
      if (cnt_en) begin
        if (period == '0 || tick) count <= '0;
        else                      count <= count + DATA_W'(1);
      end
    end
  end
endmodule

// File: rtl/pit_axi_lite_slave.sv
// AXI4-Lite slave with CTRL / PERIOD / COUNT registers around pit_counter.
// Ports:
//   aclk, aresetn   clock, asynchronous active-low reset
//   s_axi           AXI4-Lite slave modport (pit_axi_if)
//   irq             one-cycle interrupt pulse
//   dbg_wr_state    current write FSM state
//   dbg_rd_state    current read FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The master holds valid and payload stable until then. awready,
// wready and arready are combinational and high only while the owning FSM is
// idle and its valids are present (awvalid AND wvalid for writes), so the
// handshake cycle is the cycle the master first presents the request.
// bvalid/rvalid are registered and held with stable payload until bready/rready.
module pit_axi_lite_slave
  import pit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic      aclk,
  input  logic      aresetn,
  pit_axi_if.slave  s_axi,
  output logic      irq,
  output wr_state_t dbg_wr_state,
  output rd_state_t dbg_rd_state
);
  wr_state_t         wr_state;
  rd_state_t         rd_state;
  logic              cnt_en_q;
  logic              irq_en_q;
  logic [DATA_W-1:0] period_q;
  logic [DATA_W-1:0] count;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic              rvalid_q;
  logic [1:0]        rresp_q;
  logic [DATA_W-1:0] rdata_q;
  logic              wr_accept;
  logic              rd_accept;
  logic [1:0]        wr_word;
  logic [1:0]        rd_word;
  logic              unused_bits;

  assign wr_word = s_axi.awaddr[3:2];
  assign rd_word = s_axi.araddr[3:2];

  // Gated by aresetn so the readies fall with reset, not one edge later.
  assign wr_accept = aresetn && (wr_state == W_IDLE) && s_axi.awvalid && s_axi.wvalid;
  assign rd_accept = aresetn && (rd_state == R_IDLE) && s_axi.arvalid;

  assign s_axi.awready = wr_accept;
  assign s_axi.wready  = wr_accept;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = rd_accept;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  assign dbg_wr_state = wr_state;
  assign dbg_rd_state = rd_state;

  assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                         s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  // Write FSM and register file. Registers load at the end of the handshake
  // cycle, so the counter sees the new CTRL from the following cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state <= W_IDLE;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      cnt_en_q <= 1'b0;
      irq_en_q <= 1'b0;
      period_q <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (wr_accept) begin
            wr_state <= W_RESP;
            bvalid_q <= 1'b1;
            bresp_q  <= RESP_OKAY;
            case (wr_word)
              ADDR_CTRL: begin
                if (s_axi.wstrb[0]) begin
                  cnt_en_q <= s_axi.wdata[CNT_EN_BIT];
                  irq_en_q <= s_axi.wdata[IRQ_EN_BIT];
                end
              end
              ADDR_PERIOD: period_q <= apply_wstrb(period_q, s_axi.wdata, s_axi.wstrb);
              ADDR_COUNT:  ;  // read-only: response only
              default:     bresp_q <= RESP_SLVERR;
            endcase
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            wr_state <= W_IDLE;
            bvalid_q <= 1'b0;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: data is captured in the handshake cycle and held until rready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state <= R_IDLE;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (rd_accept) begin
            rd_state <= R_DATA;
            rvalid_q <= 1'b1;
            rresp_q  <= RESP_OKAY;
            case (rd_word)
              ADDR_CTRL:   rdata_q <= {{(DATA_W-2){1'b0}}, irq_en_q, cnt_en_q};
              ADDR_PERIOD: rdata_q <= period_q;
              ADDR_COUNT:  rdata_q <= count;
              default: begin
                rdata_q <= '0;
                rresp_q <= RESP_SLVERR;
              end
            endcase
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            rd_state <= R_IDLE;
            rvalid_q <= 1'b0;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  pit_counter #(.DATA_W(DATA_W)) u_counter (
    .aclk    (aclk),
    .aresetn (aresetn),
    .cnt_en  (cnt_en_q),
    .irq_en  (irq_en_q),
    .period  (period_q),
    .count   (count),
    .irq     (irq)
  );
endmodule
